// File: rtl/sysid_check_pkg.sv
// Shared types and defaults for the sysid boot checker: FSM states, sysid word addresses,
// bus widths and default expected ID/timestamp values.
package sysid_check_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WAIT_W  = 16;
    localparam int unsigned RETRY_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        EVAL,
        DONE
    } state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [DATA_W-1:0]  DEFAULT_EXPECTED_ID    = 32'd0;
    localparam logic [DATA_W-1:0]  DEFAULT_EXPECTED_TS    = 32'd1457099724;
    localparam logic [WAIT_W-1:0]  DEFAULT_TIMEOUT_CYCLES = 16'd255;
    localparam logic [RETRY_W-1:0] DEFAULT_MAX_RETRIES    = 2'd3;

endpackage

// File: rtl/sysid_wait_timer.sv
// Counts stalled read cycles; expire rises once TIMEOUT_CYCLES stalls have accumulated
// since the last clear. The count saturates so it can never wrap back below the limit.
module sysid_wait_timer
    import sysid_check_pkg::*;
#(
    parameter logic [WAIT_W-1:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TIMEOUT_CYCLES)) begin
            count <= count + WAIT_W'(1);
        end
    end

    assign expire = (count == TIMEOUT_CYCLES);

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid check: reads ID and timestamp words over Avalon-MM, compares them and retries
// on mismatch. Define SYSID_CHECK_TIMEOUT_EN to abort reads stalled for TIMEOUT_CYCLES cycles.
module sysid_boot_checker
    import sysid_check_pkg::*;
#(
    parameter logic [DATA_W-1:0]  EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [DATA_W-1:0]  EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter logic [WAIT_W-1:0]  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [RETRY_W-1:0] MAX_RETRIES    = DEFAULT_MAX_RETRIES
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    output logic               busy,
    output logic               done,
    output logic               id_ok,
    output logic               ts_ok,
    output logic               timeout_err,
    output logic [RETRY_W-1:0] retry_cnt
);

    state_e            state;
    logic [DATA_W-1:0] id_data;
    logic [DATA_W-1:0] ts_data;
    logic              timer_expire;
    logic              id_match_c;
    logic              ts_match_c;
    logic              abort_c;

    assign id_match_c = (id_data == EXPECTED_ID);
    assign ts_match_c = (ts_data == EXPECTED_TS);
    // A completing read always wins over an expiring timer.
    assign abort_c    = avm_read & avm_waitrequest & timer_expire;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic timer_clear_c;
    logic timer_enable_c;

    // Counter restarts whenever no stall is in progress, so every read-state entry sees zero.
    assign timer_enable_c = avm_read & avm_waitrequest;
    assign timer_clear_c  = ~avm_read | ~avm_waitrequest | timer_expire;

    sysid_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear_c),
        .enable  (timer_enable_c),
        .expire  (timer_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timer_expire       = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt   <= '0;
            id_data     <= '0;
            ts_data     <= '0;
        end else if (abort_c) begin
            if (retry_cnt < MAX_RETRIES) begin
                retry_cnt   <= retry_cnt + RETRY_W'(1);
                state       <= RD_ID;
                avm_address <= ADDR_ID;
            end else begin
                state       <= DONE;
                avm_read    <= 1'b0;
                avm_address <= ADDR_ID;
                busy        <= 1'b0;
                done        <= 1'b1;
                timeout_err <= 1'b1;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
            end
        end else begin
            case (state)
                // Boot check starts on its own right after reset.
                IDLE: begin
                    state       <= RD_ID;
                    avm_read    <= 1'b1;
                    avm_address <= ADDR_ID;
                    busy        <= 1'b1;
                end
                RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_data     <= avm_readdata;
                        state       <= RD_TS;
                        avm_address <= ADDR_TS;
                    end
                end
                RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_data     <= avm_readdata;
                        state       <= EVAL;
                        avm_read    <= 1'b0;
                        avm_address <= ADDR_ID;
                    end
                end
                EVAL: begin
                    id_ok <= id_match_c;
                    ts_ok <= ts_match_c;
                    if ((id_match_c && ts_match_c) || (retry_cnt >= MAX_RETRIES)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        retry_cnt   <= retry_cnt + RETRY_W'(1);
                        state       <= RD_ID;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ID;
                    end
                end
                DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                        retry_cnt   <= '0;
                        state       <= RD_ID;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ID;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: a scripted Avalon slave replays a per-pass plan,
// a pass-level reference model predicts results and completion cycle, a monitor checks on done.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1457099724;
    localparam int          TMO    = 8;
    localparam int          MAXR   = 3;
`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // wid/wts: stall cycles before the slave answers; negative means it never answers.
    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        int          wid;
        int          wts;
    } pass_t;

    typedef struct {
        bit     id_ok;
        bit     ts_ok;
        bit     tmo;
        int     retries;
        int     lat;
        longint t_done;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b1;
    logic [31:0] avm_readdata = '0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [1:0]  retry_cnt;

    pass_t  plan [4];
    exp_t   expq [$];
    int     seq = 0;
    longint cyc = 0;
    int     n_total = 0;
    int     n_pass = 0;

    sysid_boot_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (16'(TMO)),
        .MAX_RETRIES    (2'(MAXR))
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .retry_cnt       (retry_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Pass-by-pass outcome of a check: each pass either aborts, matches, or retries.
    function automatic exp_t model();
        exp_t r;
        r = '{default: 0};
        for (int p = 0; p <= MAXR; p++) begin
            r.retries = p;
            if (TMO_EN && plan[p].wid < 0) begin
                r.lat += TMO + 1;
                if (p == MAXR) begin r.tmo = 1; r.id_ok = 0; r.ts_ok = 0; return r; end
                continue;
            end
            r.lat += plan[p].wid + 1;
            if (TMO_EN && plan[p].wts < 0) begin
                r.lat += TMO + 1;
                if (p == MAXR) begin r.tmo = 1; r.id_ok = 0; r.ts_ok = 0; return r; end
                continue;
            end
            r.lat += plan[p].wts + 2;
            r.id_ok = (plan[p].id == EXP_ID);
            r.ts_ok = (plan[p].ts == EXP_TS);
            if ((r.id_ok && r.ts_ok) || p == MAXR) return r;
        end
        return r;
    endfunction

    // Scripted slave: tracks which word of which pass it is serving.
    int s_pass = 0, s_word = 0, s_waited = 0, s_seen = 0, s_w = 0;
    bit s_prev_rd = 0, s_prev_wr = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            s_pass = 0; s_word = 0; s_waited = 0; s_prev_rd = 0; s_seen = seq;
            avm_waitrequest = 1'b1;
        end else begin
            if (seq != s_seen) begin
                s_seen = seq; s_pass = 0; s_word = 0; s_waited = 0; s_prev_rd = 0;
            end
            if (s_prev_rd) begin
                if (!s_prev_wr) begin
                    s_waited = 0;
                    if (s_word == 0) s_word = 1;
                    else begin s_word = 0; s_pass++; end
                end else begin
                    s_waited++;
                    if (TMO_EN && s_waited == TMO + 1) begin
                        s_waited = 0; s_word = 0; s_pass++;
                    end
                end
            end
            if (s_pass > MAXR) s_pass = MAXR;
            s_w = (s_word != 0) ? plan[s_pass].wts : plan[s_pass].wid;
            s_prev_rd = avm_read;
            if (s_w < 0 || s_waited < s_w) begin
                avm_waitrequest = 1'b1;
                avm_readdata    = $urandom;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata    = (s_word != 0) ? plan[s_pass].ts : plan[s_pass].id;
            end
            s_prev_wr = avm_waitrequest;
        end
    end

    // Monitor: every rising done consumes one expectation.
    initial begin : monitor
        exp_t e;
        bit   done_q;
        done_q = 1'b0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (done && !done_q) begin
                if (expq.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = expq.pop_front();
                    check("id_ok", id_ok, e.id_ok);
                    check("ts_ok", ts_ok, e.ts_ok);
                    check("timeout_err", timeout_err, e.tmo);
                    check("retry_cnt", retry_cnt, e.retries);
                    check("done_cycle", cyc, e.t_done);
                    check("busy_at_done", busy, 0);
                    check("read_at_done", avm_read, 0);
                end
            end
            done_q = done;
        end
    end

    task automatic set_all(input logic [31:0] id, input logic [31:0] ts, input int wid, input int wts);
        for (int p = 0; p < 4; p++) plan[p] = '{id, ts, wid, wts};
    endtask

    task automatic rand_plan();
        for (int p = 0; p < 4; p++) begin
            plan[p].id  = ($urandom_range(3, 0) == 0) ? ($urandom | 32'h1) : EXP_ID;
            plan[p].ts  = ($urandom_range(3, 0) == 0) ? (EXP_TS ^ (32'h1 << $urandom_range(31, 0))) : EXP_TS;
            plan[p].wid = (TMO_EN && $urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(3, 0));
            plan[p].wts = (TMO_EN && $urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(3, 0));
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e = model();
        e.t_done = cyc + 1 + e.lat;
        expq.push_back(e);
    endtask

    // Release reset; the checker must start its boot check by itself.
    task automatic boot();
        @(negedge clock);
        push_expect();
        seq++;
        reset_n = 1'b1;
    endtask

    task automatic issue(input bit expect_done);
        @(negedge clock);
        if (expect_done) push_expect();
        start = 1'b1;
        seq++;
        @(negedge clock);
        start = 1'b0;
        check("clr_done", done, 0);
        check("clr_retry", retry_cnt, 0);
        check("clr_id_ok", id_ok, 0);
        check("clr_ts_ok", ts_ok, 0);
        check("clr_timeout", timeout_err, 0);
        check("busy_on_start", busy, 1);
        check("read_on_start", avm_read, 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || !done) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("completion_in_budget", (expq.size() == 0 && done) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"}, avm_read, 0);
        check({tag, "_addr"}, avm_address, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_id_ok"}, id_ok, 0);
        check({tag, "_ts_ok"}, ts_ok, 0);
        check({tag, "_timeout"}, timeout_err, 0);
        check({tag, "_retry"}, retry_cnt, 0);
    endtask

    initial begin
        set_all(EXP_ID, EXP_TS, 0, 0);
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clock);

        // Zero-wait boot check with correct data.
        boot();
        wait_done(200);

        // Wrong ID on every pass exhausts the retries.
        set_all(32'h5, EXP_TS, 0, 0);
        issue(1);
        wait_done(200);

        // One bad pass, then good data.
        set_all(EXP_ID, EXP_TS, 1, 2);
        plan[0].id = 32'h5;
        issue(1);
        wait_done(200);

        // Start pulsed while busy has no effect on the running check.
        set_all(EXP_ID, EXP_TS, 2, 2);
        issue(1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_ignore_start", busy, 1);
        wait_done(200);

        // Slave never answers.
        set_all(EXP_ID, EXP_TS, -1, 0);
`ifdef SYSID_CHECK_TIMEOUT_EN
        issue(1);
        wait_done(300);
`else
        issue(0);
        repeat (40) @(negedge clock);
        check("stuck_busy", busy, 1);
        check("stuck_read", avm_read, 1);
        check("stuck_done", done, 0);
        reset_n = 1'b0;
        set_all(EXP_ID, EXP_TS, 0, 0);
        boot();
        wait_done(200);
`endif

        for (int i = 0; i < 25; i++) begin
            rand_plan();
            issue(1);
            wait_done(400);
        end

        // Reset in the middle of a stalled timestamp read.
        set_all(EXP_ID, EXP_TS, 0, -1);
        issue(0);
        @(negedge clock);
        check("rd_ts_addr", avm_address, 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        set_all(EXP_ID, EXP_TS, 0, 0);
        boot();
        wait_done(200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
